// File: rtl/bm_pkg.sv
// Shared types for the block-matching pipeline.
//   COST_W      : width of a Hamming cost
//   coords_t    : pixel coordinates {y, x}
//   wta_state_t : winner-take-all selector state
//   cand_t      : one disparity candidate {cost, idx}
package bm_pkg;

  localparam int COST_W = 8;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
  } coords_t;

  typedef enum logic {
    IDLE,
    SEARCH
  } wta_state_t;

  typedef struct packed {
    logic [COST_W-1:0] cost;
    logic [7:0]        idx;
  } cand_t;

endpackage

// File: rtl/wta_update.sv
// Combinational best/runner-up update for one disparity candidate.
// Ports:
//   first         : candidate starts a new pixel (re-initialise)
//   best_cost/idx : current winner
//   second        : current runner-up cost (excludes winner's neighbours)
//   cand_cost/idx : incoming candidate
//   nxt_*         : updated winner / runner-up
module wta_update #(
  parameter int DISP_W = 6,
  parameter int COST_W = 8
) (
  input  logic              first,
  input  logic [COST_W-1:0] best_cost,
  input  logic [DISP_W-1:0] best_idx,
  input  logic [COST_W-1:0] second,
  input  logic [COST_W-1:0] cand_cost,
  input  logic [DISP_W-1:0] cand_idx,
  output logic [COST_W-1:0] nxt_best_cost,
  output logic [DISP_W-1:0] nxt_best_idx,
  output logic [COST_W-1:0] nxt_second
);

  localparam logic [DISP_W-1:0] ONE = DISP_W'(1);

  always_comb begin
    nxt_best_cost = best_cost;
    nxt_best_idx  = best_idx;
    nxt_second    = second;
    if (first) begin
      nxt_best_cost = cand_cost;
      nxt_best_idx  = cand_idx;
      nxt_second    = '1;
    end else if (cand_cost < best_cost) begin
      // The displaced winner only becomes runner-up if it is not the
      // immediate neighbour of the new winner.
      if (best_idx != cand_idx - ONE)
        nxt_second = best_cost;
      nxt_best_cost = cand_cost;
      nxt_best_idx  = cand_idx;
    end else if ((cand_idx != best_idx + ONE) && (cand_cost < second)) begin
      nxt_second = cand_cost;
    end
  end

endmodule

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selector. Accepts candidates 0..NUM_DISP-1 of
// one pixel in order and emits best disparity, best cost, non-adjacent
// runner-up cost and a confidence flag one cycle after the last candidate.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   sum_i               : candidate cost
//   coords_i            : candidate pixel coords {y, x}
//   blk_index_i         : candidate index (disparity)
//   sum_valid_i         : candidate valid
//   cfg_uniq_margin     : required runner-up minus best margin (latched at idx 0)
//   cfg_max_cost        : maximum accepted best cost (latched at idx 0)
//   disp_o, cost_o      : winning disparity and cost
//   cost2_o             : runner-up cost
//   coords_o            : pixel coords of the result
//   match_ok_o          : margin and max-cost tests passed
//   result_valid_o      : one-cycle result strobe
//   seq_err_o           : sticky sequence error
//
// state  | meaning
// IDLE   | waiting for a valid candidate with index 0
// SEARCH | accumulating candidates of one pixel
module disparity_wta #(
  parameter int NUM_DISP = 64,
  parameter int DISP_W   = $clog2(NUM_DISP),
  parameter int COST_W   = bm_pkg::COST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COST_W-1:0] sum_i,
  input  logic [15:0]       coords_i,
  input  logic [15:0]       blk_index_i,
  input  logic              sum_valid_i,
  input  logic [COST_W-1:0] cfg_uniq_margin,
  input  logic [COST_W-1:0] cfg_max_cost,
  output logic [DISP_W-1:0] disp_o,
  output logic [COST_W-1:0] cost_o,
  output logic [COST_W-1:0] cost2_o,
  output logic [15:0]       coords_o,
  output logic              match_ok_o,
  output logic              result_valid_o,
  output logic              seq_err_o
);

  import bm_pkg::*;

  localparam logic [15:0] LAST_IDX = 16'(NUM_DISP - 1);

  wta_state_t        state, state_nxt;
  logic [15:0]       exp_idx;
  coords_t           lat_coords;
  logic [COST_W-1:0] lat_margin, lat_max;
  logic [COST_W-1:0] best_cost, second;
  logic [DISP_W-1:0] best_idx;
  logic [COST_W-1:0] upd_best_cost, upd_second;
  logic [DISP_W-1:0] upd_best_idx;
  logic              do_init, do_accept, do_final, set_err;
  logic [COST_W:0]   gap;
  logic              match_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_init   = 1'b0;
    do_accept = 1'b0;
    set_err   = 1'b0;
    if (sum_valid_i) begin
      case (state)
        IDLE: begin
          if (blk_index_i == 16'd0) begin
            do_init   = 1'b1;
            state_nxt = SEARCH;
          end else begin
            set_err = 1'b1;
          end
        end
        SEARCH: begin
          if ((blk_index_i == exp_idx) && (coords_i == lat_coords)) begin
            do_accept = 1'b1;
            if (blk_index_i == LAST_IDX)
              state_nxt = IDLE;
          end else if (blk_index_i == 16'd0) begin
            // Restart on a fresh index 0; the abandoned pixel yields nothing.
            set_err = 1'b1;
            do_init = 1'b1;
          end else begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign do_final = do_accept && (blk_index_i == LAST_IDX);

  wta_update #(
    .DISP_W(DISP_W),
    .COST_W(COST_W)
  ) u_update (
    .first        (do_init),
    .best_cost    (best_cost),
    .best_idx     (best_idx),
    .second       (second),
    .cand_cost    (sum_i),
    .cand_idx     (blk_index_i[DISP_W-1:0]),
    .nxt_best_cost(upd_best_cost),
    .nxt_best_idx (upd_best_idx),
    .nxt_second   (upd_second)
  );

  // Evaluated on the post-update values so the last candidate counts.
  assign gap      = {1'b0, upd_second} - {1'b0, upd_best_cost};
  assign match_ok = (gap >= {1'b0, lat_margin}) && (upd_best_cost <= lat_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_idx        <= '0;
      lat_coords     <= '0;
      lat_margin     <= '0;
      lat_max        <= '0;
      best_cost      <= '0;
      best_idx       <= '0;
      second         <= '0;
      disp_o         <= '0;
      cost_o         <= '0;
      cost2_o        <= '0;
      coords_o       <= '0;
      match_ok_o     <= 1'b0;
      result_valid_o <= 1'b0;
      seq_err_o      <= 1'b0;
    end else begin
      result_valid_o <= do_final;
      if (do_init || do_accept) begin
        best_cost <= upd_best_cost;
        best_idx  <= upd_best_idx;
        second    <= upd_second;
      end
      if (do_init) begin
        exp_idx    <= 16'd1;
        lat_coords <= coords_i;
        lat_margin <= cfg_uniq_margin;
        lat_max    <= cfg_max_cost;
      end else if (do_accept) begin
        exp_idx <= exp_idx + 16'd1;
      end
      if (do_final) begin
        disp_o     <= upd_best_idx;
        cost_o     <= upd_best_cost;
        cost2_o    <= upd_second;
        coords_o   <= lat_coords;
        match_ok_o <= match_ok;
      end
      if (set_err)
        seq_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_disparity_wta.sv
// Directed bench for disparity_wta with NUM_DISP=4.
module tb_disparity_wta;

  localparam int ND = 4;

  typedef struct packed {
    logic [3:0][7:0] costs;
    logic [15:0]     coords;
    logic [7:0]      margin;
    logic [7:0]      maxc;
    logic [1:0]      disp;
    logic [7:0]      best;
    logic [7:0]      second;
    logic            ok;
  } vec_t;

  typedef struct packed {
    logic [1:0]  disp;
    logic [7:0]  cost;
    logic [7:0]  cost2;
    logic [15:0] coords;
    logic        ok;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sum_i;
  logic [15:0] coords_i;
  logic [15:0] blk_index_i;
  logic        sum_valid_i;
  logic [7:0]  cfg_uniq_margin;
  logic [7:0]  cfg_max_cost;
  logic [1:0]  disp_o;
  logic [7:0]  cost_o;
  logic [7:0]  cost2_o;
  logic [15:0] coords_o;
  logic        match_ok_o;
  logic        result_valid_o;
  logic        seq_err_o;

  vec_t vecs[8];
  res_t got[$];
  int   got_cyc[$];
  int   last_c[8];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   lc;

  disparity_wta #(.NUM_DISP(ND)) dut (
    .clk            (clk),
    .reset          (reset),
    .sum_i          (sum_i),
    .coords_i       (coords_i),
    .blk_index_i    (blk_index_i),
    .sum_valid_i    (sum_valid_i),
    .cfg_uniq_margin(cfg_uniq_margin),
    .cfg_max_cost   (cfg_max_cost),
    .disp_o         (disp_o),
    .cost_o         (cost_o),
    .cost2_o        (cost2_o),
    .coords_o       (coords_o),
    .match_ok_o     (match_ok_o),
    .result_valid_o (result_valid_o),
    .seq_err_o      (seq_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (result_valid_o === 1'b1) begin
      got.push_back({disp_o, cost_o, cost2_o, coords_o, match_ok_o});
      got_cyc.push_back(cyc);
    end
  end

  function automatic vec_t mk(input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3,
                              input logic [15:0] co, input logic [7:0] m,
                              input logic [7:0] mx, input logic [1:0] d,
                              input logic [7:0] b, input logic [7:0] s,
                              input logic ok);
    vec_t v;
    v.costs[0] = c0;
    v.costs[1] = c1;
    v.costs[2] = c2;
    v.costs[3] = c3;
    v.coords   = co;
    v.margin   = m;
    v.maxc     = mx;
    v.disp     = d;
    v.best     = b;
    v.second   = s;
    v.ok       = ok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_one(input logic v, input logic [7:0] c, input logic [15:0] co,
                           input logic [15:0] idx, input logic [7:0] m, input logic [7:0] mx);
    sum_valid_i     = v;
    sum_i           = c;
    coords_i        = co;
    blk_index_i     = idx;
    cfg_uniq_margin = m;
    cfg_max_cost    = mx;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_one(1'b0, 8'($urandom), 16'($urandom), 16'($urandom),
                         8'($urandom), 8'($urandom));
  endtask

  // Config is only valid alongside index 0; it is scrambled afterwards.
  task automatic drive_pixel(input vec_t v, input int gap_max, output int lastc);
    lastc = 0;
    for (int i = 0; i < ND; i++) begin
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
      if (i == ND - 1) lastc = cyc;
      if (i == 0) drive_one(1'b1, v.costs[i], v.coords, 16'(i), v.margin, v.maxc);
      else        drive_one(1'b1, v.costs[i], v.coords, 16'(i), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    sum_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_res(input string tag, input int k, input vec_t v);
    chk($sformatf("%s_disp", tag),   32'(got[k].disp),   32'(v.disp));
    chk($sformatf("%s_cost", tag),   32'(got[k].cost),   32'(v.best));
    chk($sformatf("%s_cost2", tag),  32'(got[k].cost2),  32'(v.second));
    chk($sformatf("%s_coords", tag), 32'(got[k].coords), 32'(v.coords));
    chk($sformatf("%s_ok", tag),     32'(got[k].ok),     32'(v.ok));
  endtask

  task automatic run_pass(input string tag, input int gap_max);
    got.delete();
    got_cyc.delete();
    for (int k = 0; k < 8; k++) drive_pixel(vecs[k], gap_max, last_c[k]);
    idle(3);
    chk({tag, "_count"}, 32'(got.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < got.size()) begin
        chk_res($sformatf("%s_p%0d", tag, k), k, vecs[k]);
        chk($sformatf("%s_p%0d_latency", tag, k), 32'(got_cyc[k]), 32'(last_c[k] + 1));
      end
    end
    chk({tag, "_seq_err"}, 32'(seq_err_o), 32'd0);
  endtask

  initial begin
    //             c0     c1      c2      c3      coords    margin  max    disp   best   second ok
    vecs[0] = mk(8'd20, 8'd10,  8'd30,  8'd40,  16'h0305, 8'd5,   8'd50, 2'd1, 8'd10, 8'd40,  1'b1);
    vecs[1] = mk(8'd15, 8'd10,  8'd12,  8'd11,  16'h0306, 8'd3,   8'd50, 2'd1, 8'd10, 8'd11,  1'b0);
    vecs[2] = mk(8'd7,  8'd9,   8'd7,   8'd9,   16'h0A0B, 8'd1,   8'd50, 2'd0, 8'd7,  8'd7,   1'b0);
    vecs[3] = mk(8'd60, 8'd70,  8'd80,  8'd90,  16'h1F00, 8'd10,  8'd50, 2'd0, 8'd60, 8'd80,  1'b0);
    vecs[4] = mk(8'd0,  8'd255, 8'd255, 8'd255, 16'h00FF, 8'd255, 8'd0,  2'd0, 8'd0,  8'd255, 1'b1);
    vecs[5] = mk(8'd50, 8'd40,  8'd30,  8'd20,  16'h8001, 8'd235, 8'd20, 2'd3, 8'd20, 8'd255, 1'b1);
    vecs[6] = mk(8'd30, 8'd5,   8'd5,   8'd40,  16'h4242, 8'd36,  8'd50, 2'd1, 8'd5,  8'd40,  1'b0);
    vecs[7] = mk(8'd9,  8'd20,  8'd3,   8'd8,   16'h1122, 8'd6,   8'd3,  2'd2, 8'd3,  8'd9,   1'b1);

    sum_valid_i     = 1'b0;
    sum_i           = '0;
    coords_i        = '0;
    blk_index_i     = '0;
    cfg_uniq_margin = '0;
    cfg_max_cost    = '0;
    reset           = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_disp",   32'(disp_o),         32'd0);
    chk("rst_cost",   32'(cost_o),         32'd0);
    chk("rst_cost2",  32'(cost2_o),        32'd0);
    chk("rst_coords", 32'(coords_o),       32'd0);
    chk("rst_ok",     32'(match_ok_o),     32'd0);
    chk("rst_valid",  32'(result_valid_o), 32'd0);
    chk("rst_err",    32'(seq_err_o),      32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_pass("b2b", 0);
    run_pass("gaps", 3);

    // Restart on index 0 mid-search: only the second search reports.
    do_reset();
    got.delete();
    drive_one(1'b1, 8'd1, 16'h0305, 16'd0, 8'd200, 8'd0);
    drive_one(1'b1, 8'd1, 16'h0305, 16'd1, 8'd200, 8'd0);
    drive_pixel(vecs[0], 0, lc);
    idle(3);
    chk("restart_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk_res("restart", 0, vecs[0]);
    chk("restart_err", 32'(seq_err_o), 32'd1);

    // Skipped index: abandon, no result.
    do_reset();
    got.delete();
    drive_one(1'b1, 8'd4, 16'h0305, 16'd0, 8'd1, 8'd50);
    drive_one(1'b1, 8'd4, 16'h0305, 16'd2, 8'd1, 8'd50);
    idle(4);
    chk("skip_count", 32'(got.size()), 32'd0);
    chk("skip_err", 32'(seq_err_o), 32'd1);
    drive_pixel(vecs[1], 0, lc);
    idle(2);
    chk("skip_recover_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk_res("skip_recover", 0, vecs[1]);

    // Coords change mid-search.
    do_reset();
    got.delete();
    drive_one(1'b1, 8'd4, 16'h0305, 16'd0, 8'd1, 8'd50);
    drive_one(1'b1, 8'd4, 16'h0305, 16'd1, 8'd1, 8'd50);
    drive_one(1'b1, 8'd4, 16'h0306, 16'd2, 8'd1, 8'd50);
    drive_one(1'b1, 8'd4, 16'h0306, 16'd3, 8'd1, 8'd50);
    idle(4);
    chk("coords_count", 32'(got.size()), 32'd0);
    chk("coords_err", 32'(seq_err_o), 32'd1);

    // Reset mid-search after outputs and the error flag are non-zero.
    do_reset();
    got.delete();
    drive_pixel(vecs[7], 0, lc);
    idle(2);
    drive_one(1'b1, 8'd5, 16'h0305, 16'd1, 8'd0, 8'd0);
    idle(1);
    chk("pre_rst_err", 32'(seq_err_o), 32'd1);
    chk("pre_rst_disp", 32'(disp_o), 32'd2);
    got.delete();
    drive_one(1'b1, 8'd20, 16'h0305, 16'd0, 8'd5, 8'd50);
    drive_one(1'b1, 8'd10, 16'h0305, 16'd1, 8'd5, 8'd50);
    reset       = 1'b1;
    sum_valid_i = 1'b1;
    sum_i       = 8'd30;
    blk_index_i = 16'd2;
    @(negedge clk);
    reset       = 1'b0;
    sum_valid_i = 1'b0;
    chk("mid_rst_disp",   32'(disp_o),         32'd0);
    chk("mid_rst_cost",   32'(cost_o),         32'd0);
    chk("mid_rst_cost2",  32'(cost2_o),        32'd0);
    chk("mid_rst_coords", 32'(coords_o),       32'd0);
    chk("mid_rst_ok",     32'(match_ok_o),     32'd0);
    chk("mid_rst_valid",  32'(result_valid_o), 32'd0);
    chk("mid_rst_err",    32'(seq_err_o),      32'd0);
    idle(3);
    chk("mid_rst_noresult", 32'(got.size()), 32'd0);
    drive_pixel(vecs[0], 0, lc);
    idle(3);
    chk("post_rst_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk_res("post_rst", 0, vecs[0]);
    chk("post_rst_err", 32'(seq_err_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/disparity_wta.md
Name: disparity_wta

Overview:
- Winner-take-all disparity selector. Sits directly downstream of the Hamming-distance stage.
- Consumes one (cost, coords, candidate index) per valid cycle.
- Candidates for one pixel arrive in order, index 0..NUM_DISP-1. After the last one, the block emits one result per pixel: best disparity, best cost, runner-up cost and a match-confidence flag.
- No backpressure: the upstream pipeline has none.

Parameters:
- NUM_DISP, 64, candidates per pixel (2..256).
- DISP_W, $clog2(NUM_DISP), width of disparity output.
- COST_W, 8, width of cost input and outputs.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sum_i  in  COST_W  Hamming cost of current candidate
- coords_i  in  16  pixel coords ({y[7:0], x[7:0]}) of current candidate
- blk_index_i  in  16  candidate index (disparity)
- sum_valid_i  in  1  candidate valid
- cfg_uniq_margin  in  COST_W  required (second - best) margin; sampled at index 0
- cfg_max_cost  in  COST_W  best cost must be <= this; sampled at index 0
- disp_o  out  DISP_W  winning disparity
- cost_o  out  COST_W  winning cost
- cost2_o  out  COST_W  runner-up cost (non-adjacent)
- coords_o  out  16  coords of the pixel
- match_ok_o  out  1  uniqueness and max-cost test passed
- result_valid_o  out  1  one-cycle pulse, all result outputs valid
- seq_err_o  out  1  sticky sequence-error flag

Behaviour:
- Reset: all outputs 0. State IDLE. Internal best/second registers cleared. Config latches are 0.
- States:
  - IDLE: waiting for a valid candidate with index 0.
  - SEARCH: accumulating candidates.
- Valid cycles with sum_valid_i=0 are ignored in every state. Gaps inside a search are legal.
- IDLE:
  - Valid with index 0 → init best=(sum_i,0), second=all-ones, exp_idx=1. Latch coords_i and cfg_*. Go to SEARCH.
  - Valid with index != 0 → drop it, set seq_err_o.
- SEARCH, valid candidate (c,i):
  - i==exp_idx and coords_i==latched coords → apply the update rule, then exp_idx++.
  - i==0 → abandon current search (no result), set seq_err_o, re-init from this candidate. Stay in SEARCH.
  - Any other index or coords mismatch → abandon, set seq_err_o, go to IDLE.
- Update rule (strict compares; ties keep the lower index):
  - c < best_cost: if best_idx != i-1, second=best_cost; otherwise second is unchanged. Then best=(c,i).
  - Otherwise: if i != best_idx+1 and c < second, second=c.
- Finalize: when the accepted candidate has i==NUM_DISP-1, the next cycle drives:
  - disp_o=best_idx, cost_o=best_cost, cost2_o=second, coords_o=latched coords.
  - match_ok_o=(second-best_cost >= margin) && (best_cost <= max_cost), using unsigned arithmetic on COST_W+1 bits.
  - result_valid_o=1 for exactly one cycle.
  - State returns to IDLE.
- Latency: result_valid_o is asserted 1 cycle after the last candidate's valid cycle.
- Back-to-back pixels: index 0 of the next pixel may arrive in the cycle right after the last candidate. Finalize and re-init must coexist, with no bubble.
- Result outputs hold their values until the next result. Only result_valid_o pulses.
- seq_err_o clears only on reset.
- Reset mid-search: the search is discarded and no result is produced.
- NUM_DISP==2 degenerate case: second stays all-ones when the two candidates are adjacent. This is legal.

Decomposition:
- Shared package bm_pkg:
  - COST_W.
  - Coords struct {y[7:0], x[7:0]}.
  - wta_state_t enum {IDLE, SEARCH}.
  - Candidate struct {cost, idx}.
- One natural sub-module: wta_update, purely combinational. Takes current best/second, candidate and first-flag; returns next best/second. It is reused in the verification reference model.

Test Plan:
1. NUM_DISP=4, coords 0x0305, costs [20,10,30,40], margin 5, max 50 → disp_o=1, cost_o=10, cost2_o=40, match_ok_o=1 (candidates 0 and 2 are adjacent to best and excluded), pulse 1 cycle after index 3.
2. Costs [15,10,12,11], margin 3 → disp 1, second=11 (idx 3), margin 1 → match_ok_o=0. Ties: costs [7,9,7,9] → disp 0, cost2_o=7 (idx 2 is non-adjacent to 0), match_ok_o=0 for margin 1.
3. Two pixels back-to-back (8 consecutive valid cycles) → two result pulses, 4 cycles apart, correct coords each. Repeat with random sum_valid_i gaps → same results.
4. Index sequence 0,1,0,1,2,3 → seq_err_o=1, single result from the second search. Sequence 0,2 → seq_err_o=1, IDLE, no result.
5. Coords change mid-search (0x0305 → 0x0306 at index 2) → seq_err_o=1, no result. Reset asserted at index 2 → outputs 0, seq_err_o=0, and a subsequent clean pixel yields a correct result.
6. Best cost 60 with max_cost 50 and a large margin → match_ok_o=0. Runner-up all-ones, best 0, margin 255 → match_ok_o=1 (no overflow).
